md_to_doy: RTL and testbench
============================

# md_to_doy

Inverse of the calendar day-of-year counter. It accepts a month/date pair through a valid/ready handshake, validates it against a non-leap 365-day year, and returns the 0-based day-of-year index (Jan 1 = 0, Dec 31 = 364). Its encoding matches the counter's `datyear` value, so the result loads the counter directly when the user sets the date. It is computed by a small FSM that walks the preceding months and accumulates their lengths, one month per cycle.

## Interface
- No parameters; year length fixed at 365 (no leap years).
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset; forces IDLE and the output reset values below.
- `req`  in  1  request valid; sampled with `month`/`date` when `ready`=1.
- `month`  in  7  requested month, legal 1..12.
- `date`  in  7  requested day of month, legal 1..days_in_month(month).
- `ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `req`&`ready`.
- `busy`  out  1  high in CHECK, ACCUM, DONE (= !`ready`).
- `done`  out  1  one-cycle pulse when result is valid.
- `doy`  out  9  day-of-year result 0..364; registered, held until next `done`.
- `err`  out  1  request invalid; registered alongside `doy`, held until next `done`.

## Operation
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `doy`=0, `err`=0; internal latches `m_q`, `d_q`, `acc`, `idx` = 0.
- IDLE: on `req`&`ready`, latch `month`→`m_q`, `date`→`d_q`; go CHECK. Otherwise stay.
- CHECK: invalid if `m_q`∉1..12, `d_q`=0, or `d_q`>dim(`m_q`).
  - Invalid: next state DONE, loading `doy`←0 and `err`←1.
  - Valid: `acc`←`d_q`−1 and `idx`←1; go ACCUM.
- ACCUM: if `idx`==`m_q`, go DONE, loading `doy`←`acc` and `err`←0. Else `acc`←`acc`+dim(`idx`), `idx`←`idx`+1, stay.
- DONE: `done`=1 for exactly this cycle; next state IDLE unconditionally.
- dim(): 31,28,31,30,31,30,31,31,30,31,30,31 for months 1..12; returns 0 for out-of-range months.
- Arithmetic: `acc` is 9 bits; max value 364, so no overflow. `idx` is 4 bits. Inputs are zero-extended and never truncated before the check, so month 0x4C is invalid, not month 12.
- `req` while busy is ignored, with no queuing. Inputs may change freely after acceptance.
- Reset asserted in any state: immediate return to IDLE with reset values; no `done` pulse for the aborted request.

## Timing
- Cycle 0: the accept cycle (`req`&`ready` sampled at its closing edge). Cycle 1: CHECK.
- Valid request: ACCUM occupies cycles 2..`m_q`+1; `done` is high in cycle `m_q`+2, so latency is 3 (Jan) to 14 (Dec) cycles.
- Invalid request: `done` is high in cycle 2.
- `doy`/`err` change only at the edge entering DONE and are stable during the `done` cycle.
- `ready` returns high the cycle after DONE. Back-to-back requests therefore have one idle-to-accept cycle of overhead.

## Structure
- Shared package `cal_pkg`:
  - `MONTHS`=12, `DAYS_PER_YEAR`=365.
  - Typedefs `doy_t` (logic[8:0]) and `md_t` (logic[6:0]).
  - State enum `md2d_state_t` {IDLE, CHECK, ACCUM, DONE}.
  - The month-length table. The forward counter uses it too.
- One sub-module, `dim_rom`: combinational 4-bit month → 5-bit day count, 0 for illegal months. Instantiated once (indexed by `idx` in ACCUM and by `m_q` in CHECK via a mux).

## Test plan
- Reset: hold `rst`=0, drive `req`=1 → `ready`=1, `done`=0, `doy`=0, `err`=0. Release, then send Jan 1 → `done` in cycle 3, `doy`=0, `err`=0.
- Mar 1 → `done` in cycle 5 with `doy`=59. Dec 31 → `done` in cycle 14 with `doy`=364. Sweep all 365 legal pairs; each `doy` must equal the forward counter's value for that date.
- Invalid pairs each give `done` in cycle 2, `err`=1, `doy`=0:
  - Feb 29
  - Apr 31
  - month 0
  - month 13
  - date 0
  - month 0x4C
- `req` held high throughout a Dec request with `month`/`date` toggling → exactly one `done`, result for the latched Dec value, next accept only after `ready` rises.
- Assert `rst` during ACCUM of an Oct request → no `done`, outputs at reset values, `ready`=1. A new Feb 28 request then yields `doy`=58.
- After one result, run an erroring request → `doy`/`err` hold the previous result until the new `done` edge, then switch to 0/1.

Source files
------------

// File: rtl/cal_pkg.sv
// -----------------------------------------------------------------------------
// cal_pkg
// Shared calendar definitions for the day-of-year counter and its inverse
// (md_to_doy). The year is fixed at 365 days and has no leap years.
//   MONTHS, DAYS_PER_YEAR : calendar constants
//   doy_t                 : 9-bit day-of-year index (0..364)
//   md_t                  : 7-bit month / date field
//   md2d_state_t          : md_to_doy controller states
//   dim_of()              : month-length table, 0 for illegal months
// -----------------------------------------------------------------------------
package cal_pkg;

  localparam int MONTHS        = 12;
  localparam int DAYS_PER_YEAR = 365;

  typedef logic [8:0] doy_t;
  typedef logic [6:0] md_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } md2d_state_t;

  // Month-length table (non-leap). Months outside 1..12 report 0 days, which
  // makes every date in them fail the range check.
  function automatic logic [4:0] dim_of(input logic [3:0] m);
    logic [4:0] days;
    case (m)
      4'd1:    days = 5'd31;
      4'd2:    days = 5'd28;
      4'd3:    days = 5'd31;
      4'd4:    days = 5'd30;
      4'd5:    days = 5'd31;
      4'd6:    days = 5'd30;
      4'd7:    days = 5'd31;
      4'd8:    days = 5'd31;
      4'd9:    days = 5'd30;
      4'd10:   days = 5'd31;
      4'd11:   days = 5'd30;
      4'd12:   days = 5'd31;
      default: days = 5'd0;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/dim_rom.sv
// -----------------------------------------------------------------------------
// dim_rom
// Combinational month-length lookup.
//   month : 4-bit month number (legal 1..12)
//   days  : 5-bit number of days in that month, 0 for illegal months
// -----------------------------------------------------------------------------
module dim_rom
  import cal_pkg::*;
(
  input  logic [3:0] month,
  output logic [4:0] days
);

  // Table lookup through the shared package function.
  always_comb begin
    days = dim_of(month);
  end

endmodule

// File: rtl/md_to_doy.sv
// -----------------------------------------------------------------------------
// md_to_doy
// Converts a month/date pair to the 0-based day-of-year index used by the
// calendar counter (Jan 1 = 0, Dec 31 = 364), non-leap year. A small FSM
// validates the request, then walks the preceding months adding one month
// length per cycle.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   req   : request valid, accepted when ready is high
//   month : requested month (legal 1..12)
//   date  : requested day of month (legal 1..days in month)
//   ready : high only in IDLE
//   busy  : inverse of ready
//   done  : one-cycle pulse, doy/err valid
//   doy   : day-of-year result, held until next done
//   err   : request was invalid, held until next done
// -----------------------------------------------------------------------------
module md_to_doy
  import cal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] month,
  input  logic [6:0] date,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [8:0] doy,
  output logic       err
);

  md2d_state_t state_r, state_s;
  md_t         m_q, m_s;
  md_t         d_q, d_s;
  doy_t        acc_r, acc_s;
  logic [3:0]  idx_r, idx_s;
  doy_t        doy_r, doy_s;
  logic        err_r, err_s;
  logic        ready_r, busy_r, done_r;

  logic [3:0]  rom_addr_s;
  logic [4:0]  rom_days_s;
  logic        valid_s;

  // CHECK needs the length of the requested month, ACCUM the length of the
  // month being walked; one ROM serves both. For m_q above 15 the low bits
  // alias a real month, but the full-width range test below rejects it.
  always_comb begin
    if (state_r == CHECK) begin
      rom_addr_s = m_q[3:0];
    end else begin
      rom_addr_s = idx_r;
    end
  end

  dim_rom u_dim_rom (
    .month (rom_addr_s),
    .days  (rom_days_s)
  );

  // Request legality on the full 7-bit latched fields.
  always_comb begin
    valid_s = (m_q >= 7'd1) && (m_q <= 7'd12) &&
              (d_q != 7'd0) && (d_q <= {2'b00, rom_days_s});
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s = state_r;
    m_s     = m_q;
    d_s     = d_q;
    acc_s   = acc_r;
    idx_s   = idx_r;
    doy_s   = doy_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          m_s     = month;
          d_s     = date;
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (valid_s) begin
          acc_s   = {2'b00, d_q} - 9'd1;
          idx_s   = 4'd1;
          state_s = ACCUM;
        end else begin
          doy_s   = 9'd0;
          err_s   = 1'b1;
          state_s = DONE;
        end
      end
      ACCUM: begin
        // idx counts the month currently being added; reaching the requested
        // month means all preceding months are already in acc.
        if ({3'b000, idx_r} == m_q) begin
          doy_s   = acc_r;
          err_s   = 1'b0;
          state_s = DONE;
        end else begin
          acc_s   = acc_r + {4'b0000, rom_days_s};
          idx_s   = idx_r + 4'd1;
          state_s = ACCUM;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      m_q     <= 7'd0;
      d_q     <= 7'd0;
      acc_r   <= 9'd0;
      idx_r   <= 4'd0;
      doy_r   <= 9'd0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      m_q     <= m_s;
      d_q     <= d_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      doy_r   <= doy_s;
      err_r   <= err_s;
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign doy   = doy_r;
  assign err   = err_r;

endmodule

// File: tb/tb_md_to_doy.sv
// -----------------------------------------------------------------------------
// tb_md_to_doy
// Directed self-checking bench for md_to_doy.
// -----------------------------------------------------------------------------
module tb_md_to_doy;

  logic       clk;
  logic       rst;
  logic       req;
  logic [6:0] month;
  logic [6:0] date;
  logic       ready;
  logic       busy;
  logic       done;
  logic [8:0] doy;
  logic       err;

  int tests;
  int fails;

  // Independent month-length and cumulative-days tables (non-leap year).
  int dim_tab [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  int cum_tab [1:12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};

  md_to_doy dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .month (month),
    .date  (date),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .doy   (doy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, issue a request, and wait for done. Returns the cycle
  // number (accept cycle = 0) in which done was seen.
  task automatic send(input logic [6:0] m, input logic [6:0] d,
                      output int cyc, output logic timeout);
    @(posedge clk); #1;
    req = 1'b1; month = m; date = d;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    timeout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    int cyc;
    logic to;
    rst = 1'b0; req = 1'b1; month = 7'd1; date = 7'd1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || doy !== 9'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: ready=%b busy=%b done=%b doy=%0d err=%b, want 1 0 0 0 0",
               ready, busy, done, doy, err);
    end
    rst = 1'b1; req = 1'b0;
    send(7'd1, 7'd1, cyc, to);
    tests++;
    if (to || cyc != 3 || doy !== 9'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL jan1: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=3 doy=0 err=0",
               to, cyc, doy, err);
    end
  endtask

  task automatic test_directed();
    int cyc;
    logic to;
    send(7'd3, 7'd1, cyc, to);
    tests++;
    if (to || cyc != 5 || doy !== 9'd59 || err !== 1'b0) begin
      fails++;
      $display("FAIL mar1: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=5 doy=59 err=0",
               to, cyc, doy, err);
    end
    send(7'd12, 7'd31, cyc, to);
    tests++;
    if (to || cyc != 14 || doy !== 9'd364 || err !== 1'b0) begin
      fails++;
      $display("FAIL dec31: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=14 doy=364 err=0",
               to, cyc, doy, err);
    end
  endtask

  task automatic test_sweep();
    int cyc;
    logic to;
    int exp_doy;
    for (int m = 1; m <= 12; m++) begin
      for (int d = 1; d <= dim_tab[m]; d++) begin
        exp_doy = cum_tab[m] + d - 1;
        send(7'(m), 7'(d), cyc, to);
        tests++;
        if (to || cyc != m + 2 || doy !== 9'(exp_doy) || err !== 1'b0) begin
          fails++;
          $display("FAIL sweep m=%0d d=%0d: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=%0d doy=%0d err=0",
                   m, d, to, cyc, doy, err, m + 2, exp_doy);
        end
      end
    end
  endtask

  task automatic test_invalid();
    int cyc;
    logic to;
    logic [6:0] bad_m [6] = '{7'd2, 7'd4, 7'd0, 7'd13, 7'd5, 7'h4C};
    logic [6:0] bad_d [6] = '{7'd29, 7'd31, 7'd1, 7'd1, 7'd0, 7'd1};
    for (int i = 0; i < 6; i++) begin
      send(bad_m[i], bad_d[i], cyc, to);
      tests++;
      if (to || cyc != 2 || doy !== 9'd0 || err !== 1'b1) begin
        fails++;
        $display("FAIL invalid m=%0d d=%0d: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=2 doy=0 err=1",
                 bad_m[i], bad_d[i], to, cyc, doy, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    int done_cyc;
    logic [8:0] got;
    @(posedge clk); #1;
    req = 1'b1; month = 7'd12; date = 7'd31;
    @(posedge clk); #1;
    cyc = 1; ndone = 0; done_cyc = 0; got = 9'd0;
    while (cyc < 30) begin
      if (done === 1'b1) begin
        ndone++;
        got = doy;
        done_cyc = cyc;
      end
      if (ready === 1'b1) break;
      month = (cyc % 2 == 1) ? 7'd2 : 7'd13;
      date  = 7'(cyc);
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (ndone != 1 || got !== 9'd364 || done_cyc != 14 || cyc != 15) begin
      fails++;
      $display("FAIL held_req: dones=%0d doy=%0d done_cyc=%0d ready_cyc=%0d, want 1 364 14 15",
               ndone, got, done_cyc, cyc);
    end
    // req is still high, so the next request is taken at this edge.
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL held_req_reaccept: busy=%b ready=%b, want 1 0", busy, ready);
    end
    req = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL held_req_second: done=%b after %0d cycles, want 1", done, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int ndone;
    logic to;
    @(posedge clk); #1;
    req = 1'b1; month = 7'd10; date = 7'd15;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: busy=%b, want 1", busy);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || doy !== 9'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_vals: ready=%b busy=%b done=%b doy=%0d err=%b, want 1 0 0 0 0",
               ready, busy, done, doy, err);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_nodone: dones=%0d ready=%b, want 0 1", ndone, ready);
    end
    send(7'd2, 7'd28, cyc, to);
    tests++;
    if (to || cyc != 4 || doy !== 9'd58 || err !== 1'b0) begin
      fails++;
      $display("FAIL feb28: timeout=%b cyc=%0d doy=%0d err=%b, want cyc=4 doy=58 err=0",
               to, cyc, doy, err);
    end
  endtask

  task automatic test_err_hold();
    int cyc;
    int nbad;
    logic to;
    send(7'd3, 7'd1, cyc, to);
    tests++;
    if (to || doy !== 9'd59 || err !== 1'b0) begin
      fails++;
      $display("FAIL hold_first: doy=%0d err=%b, want 59 0", doy, err);
    end
    @(posedge clk); #1;
    req = 1'b1; month = 7'd4; date = 7'd31;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1; nbad = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (doy !== 9'd59 || err !== 1'b0) nbad++;
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (nbad != 0 || done !== 1'b1 || cyc != 2 || doy !== 9'd0 || err !== 1'b1) begin
      fails++;
      $display("FAIL hold_err: early_changes=%0d done=%b cyc=%0d doy=%0d err=%b, want 0 1 2 0 1",
               nbad, done, cyc, doy, err);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || doy !== 9'd0 || err !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_after: done=%b doy=%0d err=%b ready=%b, want 0 0 1 1",
               done, doy, err, ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    req   = 1'b0;
    month = 7'd0;
    date  = 7'd0;
    rst   = 1'b0;
    test_reset();
    test_directed();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_err_hold();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
